// File: rtl/uart_transmitter_pkg.sv
// UART transmitter shared definitions: FSM states, oversample rate,
// baud_select codes and the divisor rounding helper.
package uart_transmitter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DIV_W      = 20;

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

  localparam logic [2:0] BAUD_300    = 3'b000;
  localparam logic [2:0] BAUD_1200   = 3'b001;
  localparam logic [2:0] BAUD_4800   = 3'b010;
  localparam logic [2:0] BAUD_9600   = 3'b011;
  localparam logic [2:0] BAUD_19200  = 3'b100;
  localparam logic [2:0] BAUD_38400  = 3'b101;
  localparam logic [2:0] BAUD_57600  = 3'b110;
  localparam logic [2:0] BAUD_115200 = 3'b111;

  function automatic int unsigned baud_rate(
    input logic [2:0] sel
  );
    int unsigned r;
    unique case (sel)
      BAUD_300:    r = 300;
      BAUD_1200:   r = 1200;
      BAUD_4800:   r = 4800;
      BAUD_9600:   r = 9600;
      BAUD_19200:  r = 19200;
      BAUD_38400:  r = 38400;
      BAUD_57600:  r = 57600;
      default:     r = 115200;
    endcase
    return r;
  endfunction

  // clk_hz / (OVERSAMPLE * baud), rounded to nearest
  function automatic logic [DIV_W-1:0] baud_div(
    input int unsigned clk_hz,
    input logic [2:0]  sel
  );
    int unsigned r;
    r = baud_rate(sel);
    return DIV_W'((clk_hz + (OVERSAMPLE / 2) * r)
                  / (OVERSAMPLE * r));
  endfunction

endpackage

// File: rtl/uart_transmitter_baud_tick.sv
// Oversample tick generator: one-cycle tick_o every divisor clocks.
// Ports: clk_i, reset_i, clear_i (restart), en_i, sel_i (baud), tick_o.
import uart_transmitter_pkg::*;

module uart_baud_tick #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic [2:0] sel_i,
  output logic       tick_o
);

  localparam logic [DIV_W-1:0] DIV_0 =
    baud_div(CLK_HZ, BAUD_300);
  localparam logic [DIV_W-1:0] DIV_1 =
    baud_div(CLK_HZ, BAUD_1200);
  localparam logic [DIV_W-1:0] DIV_2 =
    baud_div(CLK_HZ, BAUD_4800);
  localparam logic [DIV_W-1:0] DIV_3 =
    baud_div(CLK_HZ, BAUD_9600);
  localparam logic [DIV_W-1:0] DIV_4 =
    baud_div(CLK_HZ, BAUD_19200);
  localparam logic [DIV_W-1:0] DIV_5 =
    baud_div(CLK_HZ, BAUD_38400);
  localparam logic [DIV_W-1:0] DIV_6 =
    baud_div(CLK_HZ, BAUD_57600);
  localparam logic [DIV_W-1:0] DIV_7 =
    baud_div(CLK_HZ, BAUD_115200);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  always_comb begin
    div = DIV_7;
    unique case (sel_i)
      BAUD_300:   div = DIV_0;
      BAUD_1200:  div = DIV_1;
      BAUD_4800:  div = DIV_2;
      BAUD_9600:  div = DIV_3;
      BAUD_19200: div = DIV_4;
      BAUD_38400: div = DIV_5;
      BAUD_57600: div = DIV_6;
      default:    div = DIV_7;
    endcase
  end

  // tick lands on the last clock of each divisor period
  assign tick_o = en_i && (cnt_q == div - DIV_W'(1));

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (clear_i || !en_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start, 8 data LSB first, even parity, stop.
// Ports: clk, reset, baud_select, Tx_EN/Tx_WR/Tx_DATA in; TxD/Tx_BUSY/Tx_DONE out.
import uart_transmitter_pkg::*;

module uart_transmitter #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  output logic       TxD,
  output logic       Tx_BUSY,
  output logic       Tx_DONE
);

  tx_state_e  state_q, state_d;
  logic [3:0] tcnt_q, tcnt_d;
  logic [2:0] bidx_q, bidx_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic [2:0] baud_q, baud_d;
  logic       txd_q, txd_d;
  logic       busy_q, busy_d;
  logic       done;
  logic       tick;
  logic       accept;

  assign accept = Tx_WR && Tx_EN && !busy_q;

  // baud_q is latched on accept, so the rate is fixed per frame
  uart_baud_tick #(
    .CLK_HZ (CLK_HZ)
  ) u_tick (
    .clk_i   (clk),
    .reset_i (reset),
    .clear_i (accept),
    .en_i    (busy_q),
    .sel_i   (baud_q),
    .tick_o  (tick)
  );

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bidx_d  = bidx_q;
    shift_d = shift_q;
    par_d   = par_q;
    baud_d  = baud_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    done    = 1'b0;
    if (!Tx_EN) begin
      state_d = ST_IDLE;
      tcnt_d  = '0;
      bidx_d  = '0;
      txd_d   = 1'b1;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          txd_d  = 1'b1;
          busy_d = 1'b0;
          if (accept) begin
            shift_d = Tx_DATA;
            par_d   = ^Tx_DATA;
            baud_d  = baud_select;
            state_d = ST_START;
            tcnt_d  = '0;
            bidx_d  = '0;
            txd_d   = 1'b0;
            busy_d  = 1'b1;
          end
        end
        ST_START, ST_DATA,
        ST_PARITY, ST_STOP: begin
          if (tick) begin
            tcnt_d = tcnt_q + 4'd1;
            // 16th tick: line moves to the next bit
            if (tcnt_q == TICK_LAST) begin
              unique case (state_q)
                ST_START: begin
                  state_d = ST_DATA;
                  bidx_d  = '0;
                  txd_d   = shift_q[0];
                end
                ST_DATA: begin
                  if (bidx_q == 3'd7) begin
                    state_d = ST_PARITY;
                    bidx_d  = '0;
                    txd_d   = par_q;
                  end else begin
                    bidx_d = bidx_q + 3'd1;
                    txd_d  = shift_q[bidx_q + 3'd1];
                  end
                end
                ST_PARITY: begin
                  state_d = ST_STOP;
                  txd_d   = 1'b1;
                end
                ST_STOP: begin
                  state_d = ST_IDLE;
                  txd_d   = 1'b1;
                  busy_d  = 1'b0;
                  done    = 1'b1;
                end
                default: begin
                  state_d = ST_IDLE;
                end
              endcase
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          txd_d   = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tcnt_q  <= '0;
      bidx_q  <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      baud_q  <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bidx_q  <= bidx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      baud_q  <= baud_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  assign TxD     = txd_q;
  assign Tx_BUSY = busy_q;
  assign Tx_DONE = done;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: frame-level model of the line,
// directed and random frames, aborts, busy writes, chaining.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] baud_select;
  logic       Tx_EN;
  logic       Tx_WR;
  logic [7:0] Tx_DATA;
  logic       TxD;
  logic       Tx_BUSY;
  logic       Tx_DONE;

  int total = 0;
  int bad   = 0;

  int         junk_at = -1;
  logic [7:0] junk_d  = 8'h00;
  bit         chain   = 1'b0;
  logic [7:0] chain_d = 8'h00;

  uart_transmitter dut (
    .clk         (clk),
    .reset       (reset),
    .baud_select (baud_select),
    .Tx_EN       (Tx_EN),
    .Tx_WR       (Tx_WR),
    .Tx_DATA     (Tx_DATA),
    .TxD         (TxD),
    .Tx_BUSY     (Tx_BUSY),
    .Tx_DONE     (Tx_DONE)
  );

  always #5 clk = ~clk;

  function automatic int ref_div(input logic [2:0] sel);
    int rates [8];
    int b;
    rates = '{300, 1200, 4800, 9600,
              19200, 38400, 57600, 115200};
    b = rates[sel];
    return (50_000_000 + 8 * b) / (16 * b);
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic idle_check(input int n, input string tag);
    int m;
    m = 0;
    repeat (n) begin
      @(negedge clk);
      if (TxD !== 1'b1 || Tx_BUSY !== 1'b0 ||
          Tx_DONE !== 1'b0) m++;
    end
    check(tag, m, 0);
  endtask

  // kind: 0 none, 1 drop Tx_EN, 2 assert reset (at abort_at)
  task automatic run_frame(input logic [7:0] d,
                           input logic [2:0] sel,
                           input int abort_at,
                           input int kind,
                           input string tag);
    int p, last, mt, mb, md, cen;
    logic [10:0] exp_f, obs_f, mask;
    logic exp_txd, exp_busy, exp_done;
    p = 16 * ref_div(sel);
    exp_f[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_f[i+1] = d[i];
    exp_f[9]  = ($countones(d) % 2) == 1;
    exp_f[10] = 1'b1;
    obs_f = '0;
    mask  = '0;
    mt = 0; mb = 0; md = 0;
    last = (abort_at >= 0) ? abort_at : 11 * p;
    Tx_DATA     = d;
    baud_select = sel;
    Tx_WR       = 1'b1;
    @(negedge clk);
    for (int c = 0; c <= last; c++) begin
      exp_txd  = (c < 11 * p) ? exp_f[c / p] : 1'b1;
      exp_busy = (c < 11 * p);
      exp_done = (c == 11 * p - 1);
      if (TxD !== exp_txd) mt++;
      if (Tx_BUSY !== exp_busy) mb++;
      if (Tx_DONE !== exp_done) md++;
      if (c < 11 * p && (c % p) == p / 2) obs_f[c / p] = TxD;
      if (c == 0) Tx_WR = 1'b0;
      if (c == junk_at) begin
        Tx_WR       = 1'b1;
        Tx_DATA     = junk_d;
        baud_select = ~sel;
      end
      if (c == junk_at + 1) Tx_WR = 1'b0;
      if (chain && c == 11 * p - 1) begin
        Tx_WR   = 1'b1;
        Tx_DATA = chain_d;
      end
      if (c == abort_at) begin
        if (kind == 1) Tx_EN = 1'b0;
        if (kind == 2) reset = 1'b1;
      end
      if (c < last) @(negedge clk);
    end
    for (int i = 0; i < 11; i++) begin
      cen = i * p + p / 2;
      if (cen <= last) mask[i] = 1'b1;
    end
    check({tag, "_txd"}, mt, 0);
    check({tag, "_busy"}, mb, 0);
    check({tag, "_done"}, md, 0);
    check({tag, "_bits"}, obs_f & mask, exp_f & mask);
    if (abort_at >= 0) begin
      @(negedge clk);
      check({tag, "_abort_txd"}, TxD, 1'b1);
      check({tag, "_abort_busy"}, Tx_BUSY, 1'b0);
      check({tag, "_abort_done"}, Tx_DONE, 1'b0);
      Tx_EN = 1'b1;
      reset = 1'b0;
      idle_check(50, {tag, "_after"});
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic [2:0] rs;
    reset       = 1'b1;
    Tx_EN       = 1'b1;
    Tx_WR       = 1'b0;
    Tx_DATA     = 8'h00;
    baud_select = 3'b111;
    repeat (5) @(negedge clk);
    check("rst_txd", TxD, 1'b1);
    check("rst_busy", Tx_BUSY, 1'b0);
    check("rst_done", Tx_DONE, 1'b0);
    reset = 1'b0;
    idle_check(1000, "idle_after_reset");

    run_frame(8'hA5, 3'b111, -1, 0, "a5");
    run_frame(8'h07, 3'b111, -1, 0, "p07");

    junk_at = 2000;
    junk_d  = 8'h3C;
    chain   = 1'b1;
    chain_d = 8'h5A;
    run_frame(8'h96, 3'b111, -1, 0, "busy_wr");
    junk_at = -1;
    chain   = 1'b0;
    run_frame(8'h5A, 3'b111, -1, 0, "chained");
    idle_check(200, "no_queue");

    run_frame(8'hB6, 3'b111, 4 * 432 + 100, 1, "en_drop");
    run_frame(8'h6D, 3'b111, 9 * 432 + 50, 2, "rst_par");

    junk_at = 100;
    junk_d  = 8'h00;
    run_frame(8'hFF, 3'b011, 3 * 5216 + 2608, 1, "b9600");
    junk_at = -1;

    for (int k = 0; k < 3; k++) begin
      rd = 8'($urandom_range(0, 255));
      rs = 3'($urandom_range(6, 7));
      run_frame(rd, rs, -1, 0, "rand");
    end
    idle_check(100, "final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
